// File: rtl/sonar_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : sonar_echo_emulator
// Function : HC-SR04-class responder. Validates the trigger pulse width, waits
//            the transducer burst delay, then returns an echo pulse whose
//            width in clk cycles comes from echo_width (0 or out of range
//            reports the no-target timeout width).
// Revision : 1.0 - initial release
// ============================================================================
module sonar_echo_emulator #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned MIN_TRIG_CYCLES = 500,
  parameter int unsigned BURST_CYCLES    = 10_000,
  parameter int unsigned MAX_ECHO_CYCLES = 1_250_000,
  parameter int unsigned TIMEOUT_CYCLES  = 1_900_000,
  parameter int unsigned HOLDOFF_CYCLES  = 500_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trigger,
  input  logic [31:0] echo_width,
  output logic        echo,
  output logic        busy,
  output logic        trig_err,
  output logic        done
);

  localparam logic [31:0] c_min_trig     = 32'(MIN_TRIG_CYCLES);
  localparam logic [31:0] c_burst_last   = 32'(BURST_CYCLES - 1);
  localparam logic [31:0] c_max_echo     = 32'(MAX_ECHO_CYCLES);
  localparam logic [31:0] c_timeout      = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] c_holdoff_last = 32'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOW = 3'd0,
    IDLE     = 3'd1,
    ARMED    = 3'd2,
    BURST    = 3'd3,
    ECHO     = 3'd4,
    HOLDOFF  = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_trig_prev;
  logic                   w_trig_s;
  logic                   w_rise;
  logic                   w_fall;

  state_t      r_state,  w_state_nxt;
  logic [31:0] r_hcnt,   w_hcnt_nxt;
  logic [31:0] r_dcnt,   w_dcnt_nxt;
  logic [31:0] r_ecnt,   w_ecnt_nxt;
  logic [31:0] r_hocnt,  w_hocnt_nxt;
  logic [31:0] r_width,  w_width_nxt;
  logic        r_echo,   w_echo_nxt;
  logic        r_busy,   w_busy_nxt;
  logic        r_err,    w_err_nxt;
  logic        r_done,   w_done_nxt;

  assign w_trig_s = r_sync[SYNC_STAGES-1];
  assign w_rise   =  w_trig_s & ~r_trig_prev;
  assign w_fall   = ~w_trig_s &  r_trig_prev;

  // Trigger synchronizer plus one-cycle delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync      <= '0;
      r_trig_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], trigger};
      r_trig_prev <= w_trig_s;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= WAIT_LOW;
      r_hcnt  <= '0;
      r_dcnt  <= '0;
      r_ecnt  <= '0;
      r_hocnt <= '0;
      r_width <= '0;
      r_echo  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_ecnt  <= w_ecnt_nxt;
      r_hocnt <= w_hocnt_nxt;
      r_width <= w_width_nxt;
      r_echo  <= w_echo_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; outputs are derived from the next state so that echo
  // and busy change on the same edge as the state register
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_dcnt_nxt  = r_dcnt;
    w_ecnt_nxt  = r_ecnt;
    w_hocnt_nxt = r_hocnt;
    w_width_nxt = r_width;
    w_err_nxt   = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      WAIT_LOW: begin
        // a trigger already high when we become ready must not count
        if (!w_trig_s) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = ARMED;
          w_hcnt_nxt  = 32'd1;
        end
      end
      ARMED: begin
        if (w_fall) begin
          if (r_hcnt >= c_min_trig) begin
            // width is frozen here; later echo_width changes do not matter
            if ((echo_width == 32'd0) || (echo_width > c_max_echo))
              w_width_nxt = c_timeout;
            else
              w_width_nxt = echo_width;
            w_dcnt_nxt  = '0;
            w_state_nxt = BURST;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (w_trig_s && (r_hcnt < c_min_trig)) begin
          w_hcnt_nxt = r_hcnt + 32'd1;
        end
      end
      BURST: begin
        if (r_dcnt == c_burst_last) begin
          w_state_nxt = ECHO;
          w_ecnt_nxt  = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + 32'd1;
        end
      end
      ECHO: begin
        if (r_ecnt == (r_width - 32'd1)) begin
          w_state_nxt = HOLDOFF;
          w_done_nxt  = 1'b1;
          w_hocnt_nxt = '0;
        end else begin
          w_ecnt_nxt = r_ecnt + 32'd1;
        end
      end
      HOLDOFF: begin
        if (r_hocnt == c_holdoff_last) w_state_nxt = WAIT_LOW;
        else                           w_hocnt_nxt = r_hocnt + 32'd1;
      end
      default: w_state_nxt = WAIT_LOW;
    endcase

    w_echo_nxt = (w_state_nxt == ECHO);
    w_busy_nxt = (w_state_nxt == BURST)   || (w_state_nxt == ECHO) ||
                 (w_state_nxt == HOLDOFF) || (w_state_nxt == WAIT_LOW);
  end

  assign echo     = r_echo;
  assign busy     = r_busy;
  assign trig_err = r_err;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sonar_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonar_echo_emulator
// Function : Self-checking bench for sonar_echo_emulator with shortened
//            timing parameters; expected echo pulses are queued when a
//            trigger is driven and matched against pulses seen on echo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonar_echo_emulator;

  localparam int SYNC    = 2;
  localparam int MIN_TRG = 10;
  localparam int BURST   = 20;
  localparam int MAX_E   = 80;
  localparam int TMO     = 100;
  localparam int HOLD    = 30;
  localparam int LIMIT   = 600;

  logic        clk;
  logic        reset_n;
  logic        trigger;
  logic [31:0] echo_width;
  logic        echo;
  logic        busy;
  logic        trig_err;
  logic        done;

  sonar_echo_emulator #(
    .SYNC_STAGES    (SYNC),
    .MIN_TRIG_CYCLES(MIN_TRG),
    .BURST_CYCLES   (BURST),
    .MAX_ECHO_CYCLES(MAX_E),
    .TIMEOUT_CYCLES (TMO),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .trigger   (trigger),
    .echo_width(echo_width),
    .echo      (echo),
    .busy      (busy),
    .trig_err  (trig_err),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int w;
    int rise;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];

  int cyc = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  int done_bad = 0;
  int last_err_cyc = -1;
  int m_rise = 0;
  int m_w = 0;
  logic m_prev = 1'b0;

  int total = 0;
  int bad = 0;
  int obs_rd = 0;

  // posedge counter: cyc holds the number of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge and log completed echo pulses
  always @(negedge clk) begin
    if (echo) begin
      if (!m_prev) begin
        m_rise = cyc;
        m_w    = 0;
      end
      m_w = m_w + 1;
    end else if (m_prev) begin
      obs_q.push_back('{w: m_w, rise: m_rise});
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      if (echo || !m_prev) done_bad = done_bad + 1;
    end
    if (trig_err) begin
      err_cnt      = err_cnt + 1;
      last_err_cyc = cyc;
    end
    m_prev = echo;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int o, input int e);
    total = total + 1;
    assert (o === e) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic trig_pulse(input int hi, output int fall_cyc);
    @(negedge clk);
    trigger = 1'b1;
    repeat (hi) @(negedge clk);
    trigger  = 1'b0;
    fall_cyc = cyc + 1;
  endtask

  task automatic run_valid(input int hi, input int w);
    int f;
    trig_pulse(hi, f);
    exp_q.push_back('{w: w, rise: f + SYNC + BURST});
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    repeat (5) @(negedge clk);
    while (busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_echo_high(input string tag);
    int n = 0;
    while (!echo && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_echo_rise"}, int'(echo), 1);
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt, target);
  endtask

  task automatic check_sb(input string tag);
    pulse_t e;
    pulse_t o;
    chk({tag, "_count"}, obs_q.size() - obs_rd, exp_q.size());
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      chk({tag, "_width"}, o.w, e.w);
      chk({tag, "_rise"}, o.rise, e.rise);
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  // Directed test sequence
  initial begin
    int e0, d0, f, dummy, bh, eh;
    trigger    = 1'b0;
    reset_n    = 1'b0;
    echo_width = 32'd40;
    repeat (3) @(negedge clk);
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_trig_err", int'(trig_err), 0);
    chk("rst_done", int'(done), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // valid 12-cycle trigger, 40-cycle echo
    e0 = err_cnt; d0 = done_cnt;
    run_valid(12, 40);
    repeat (5) @(negedge clk);
    chk("valid_busy_burst", int'(busy), 1);
    wait_quiet("valid");
    check_sb("valid");
    chk("valid_no_err", err_cnt - e0, 0);
    chk("valid_done_once", done_cnt - d0, 1);

    // short trigger rejected, then a normal one accepted
    e0 = err_cnt;
    trig_pulse(5, f);
    bh = 0; eh = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) bh++;
      if (echo) eh++;
    end
    chk("short_err_once", err_cnt - e0, 1);
    chk("short_err_cycle", last_err_cyc, f + SYNC);
    chk("short_busy_low", bh, 0);
    chk("short_echo_low", eh, 0);
    run_valid(12, 40);
    wait_quiet("after_short");
    check_sb("after_short");

    // no-target and range boundary widths
    echo_width = 32'd0;
    run_valid(12, TMO);
    wait_quiet("w0");
    echo_width = 32'd81;
    run_valid(12, TMO);
    wait_quiet("w81");
    echo_width = 32'd80;
    run_valid(12, 80);
    wait_quiet("w80");
    check_sb("range");

    // retrigger during ECHO and HOLDOFF, then a trigger held high
    echo_width = 32'd40;
    e0 = err_cnt; d0 = done_cnt;
    run_valid(12, 40);
    wait_echo_high("retrig");
    repeat (3) @(negedge clk);
    trig_pulse(12, dummy);
    wait_done("retrig", d0 + 1);
    repeat (2) @(negedge clk);
    trig_pulse(12, dummy);
    repeat (3) @(negedge clk);
    trigger = 1'b1;
    repeat (50) @(negedge clk);
    chk("held_busy_wait_low", int'(busy), 1);
    chk("held_no_echo", int'(echo), 0);
    trigger = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_release_idle", int'(busy), 0);
    chk("retrig_no_err", err_cnt - e0, 0);
    chk("retrig_done_once", done_cnt - d0, 1);
    run_valid(12, 40);
    wait_quiet("retrig_after");
    check_sb("retrig");

    // echo_width change during ECHO does not affect the pulse in progress
    run_valid(12, 40);
    wait_echo_high("wchg");
    repeat (5) @(negedge clk);
    echo_width = 32'd10;
    wait_quiet("wchg");
    run_valid(12, 10);
    wait_quiet("wchg_next");
    check_sb("wchg");

    // reset 15 cycles into ECHO truncates the pulse
    echo_width = 32'd40;
    trig_pulse(12, f);
    wait_echo_high("rst_mid");
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_echo", int'(echo), 0);
    chk("rst_mid_busy", int'(busy), 0);
    reset_n = 1'b1;
    exp_q.push_back('{w: 15, rise: f + SYNC + BURST});
    repeat (3) @(negedge clk);
    run_valid(12, 40);
    wait_quiet("rst_after");
    check_sb("rst_mid");
    chk("done_on_fall", done_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
